// File: rtl/square_draw_scheduler_if.sv
// rtl/square_draw_scheduler_if.sv - requester and VGA plot bus bundle for the square draw scheduler
interface square_draw_scheduler_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_x;
    logic [7*NREQ-1:0] req_y;
    logic [3*NREQ-1:0] req_colour;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              plot;

    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, plot
    );

    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, plot
    );
endinterface

// File: rtl/square_draw_scheduler.sv
// rtl/square_draw_scheduler.sv - round-robin arbiter serialising 4x4 sprite squares onto one VGA plot bus
module square_draw_scheduler #(
    parameter int NREQ = 4
) (
    input logic                   clk,
    input logic                   resetn,
    square_draw_scheduler_if.slave bus
);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [LW-1:0]   last_q, last_d;
    logic [3:0]      pix_q, pix_d;
    logic [7:0]      base_x_q, base_x_d;
    logic [6:0]      base_y_q, base_y_d;
    logic [2:0]      col_q, col_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_col_q, vga_col_d;
    logic            plot_q, plot_d;

    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [LW-1:0]   cidx;
    int              cand;
    logic [7:0]      win_x;
    logic [6:0]      win_y;
    logic [2:0]      win_c;

    // Search starts one past the last winner so no requester can be served twice while another waits.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        cidx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = LW'(cand);
            if (!win_found && bus.req[cidx]) begin
                win_found = 1'b1;
                win_idx   = cidx;
            end
        end
    end

    assign win_x = bus.req_x[int'(win_idx)*8 +: 8];
    assign win_y = bus.req_y[int'(win_idx)*7 +: 7];
    assign win_c = bus.req_colour[int'(win_idx)*3 +: 3];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = done_q;
        last_d    = last_q;
        pix_d     = pix_q;
        base_x_d  = base_x_q;
        base_y_d  = base_y_q;
        col_d     = col_q;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;
        plot_d    = plot_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = DRAW;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                    pix_d            = 4'd0;
                    base_x_d         = win_x;
                    base_y_d         = win_y;
                    col_d            = win_c;
                    vga_x_d          = win_x;
                    vga_y_d          = win_y;
                    vga_col_d        = win_c;
                    plot_d           = 1'b1;
                end
            end
            DRAW: begin
                pix_d = pix_q + 4'd1;
                if (pix_q == 4'd15) begin
                    state_d = DONE;
                    plot_d  = 1'b0;
                    done_d  = grant_q;
                end else begin
                    // Output registers carry the next pixel so every plot cycle is register-driven.
                    vga_x_d = base_x_q + {6'b0, pix_d[1:0]};
                    vga_y_d = base_y_q + {5'b0, pix_d[3:2]};
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = '0;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            last_q    <= LW'(NREQ - 1);
            pix_q     <= 4'd0;
            base_x_q  <= 8'd0;
            base_y_q  <= 7'd0;
            col_q     <= 3'd0;
            vga_x_q   <= 8'd0;
            vga_y_q   <= 7'd0;
            vga_col_q <= 3'd0;
            plot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            last_q    <= last_d;
            pix_q     <= pix_d;
            base_x_q  <= base_x_d;
            base_y_q  <= base_y_d;
            col_q     <= col_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
            plot_q    <= plot_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.plot       = plot_q;
endmodule

// File: tb/tb_square_draw_scheduler.sv
// tb/tb_square_draw_scheduler.sv - directed self-checking bench for square_draw_scheduler
module tb_square_draw_scheduler;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    square_draw_scheduler_if #(.NREQ(4)) bus ();

    square_draw_scheduler #(.NREQ(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.req_x[i*8 +: 8]      = x;
        bus.req_y[i*7 +: 7]      = y;
        bus.req_colour[i*3 +: 3] = c;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        steps(2);
        resetn = 1'b1;
    endtask

    // Checks all 16 pixels of a square whose first pixel is visible now; leaves the bench on the done cycle.
    task automatic chk_square(input string tag, input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
        logic [7:0] ex;
        logic [6:0] ey;
        for (int k = 0; k < 16; k++) begin
            ex = bx + 8'(k % 4);
            ey = by + 7'(k / 4);
            chk({tag, "_x"}, 32'(bus.vga_x), 32'(ex));
            chk({tag, "_y"}, 32'(bus.vga_y), 32'(ey));
            chk({tag, "_col"}, 32'(bus.vga_colour), 32'(c));
            chk({tag, "_plot"}, 32'(bus.plot), 32'd1);
            step();
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        resetn         = 1'b1;
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        #2;
        do_reset();

        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_vga_x", 32'(bus.vga_x), 32'd0);
        chk("rst_vga_y", 32'(bus.vga_y), 32'd0);
        chk("rst_vga_col", 32'(bus.vga_colour), 32'd0);

        // Single request from requester 1
        set_slot(1, 8'd10, 7'd20, 3'b100);
        bus.req = 4'b0010;
        step();
        chk("single_grant", 32'(bus.grant), 32'b0010);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk_square("single", 8'd10, 7'd20, 3'b100);
        chk("single_done", 32'(bus.done), 32'b0010);
        chk("single_done_plot", 32'(bus.plot), 32'd0);
        chk("single_done_busy", 32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        step();
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        chk("single_idle_done", 32'(bus.done), 32'd0);
        chk("single_idle_grant", 32'(bus.grant), 32'd0);
        chk("single_hold_x", 32'(bus.vga_x), 32'd13);
        chk("single_hold_y", 32'(bus.vga_y), 32'd23);
        step();
        chk("single_stay_idle", 32'(bus.busy), 32'd0);

        // All four requesting: round robin from requester 0, grants 18 cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 8'(16 * i), 7'(i), 3'(i + 1));
        bus.req = 4'b1111;
        step();
        for (int g = 0; g < 6; g++) begin
            chk("rr_grant", 32'(bus.grant), 32'(1 << (g % 4)));
            chk("rr_pix0_x", 32'(bus.vga_x), 32'(16 * (g % 4)));
            steps(16);
            chk("rr_done", 32'(bus.done), 32'(1 << (g % 4)));
            step();
            chk("rr_gap_grant", 32'(bus.grant), 32'd0);
            chk("rr_gap_busy", 32'(bus.busy), 32'd0);
            if (g == 5) bus.req = 4'b0000;
            step();
        end
        chk("rr_end_idle", 32'(bus.busy), 32'd0);

        // Fairness: requester 2 arrives mid-draw of 0 and must be served next
        do_reset();
        bus.req = 4'b0001;
        step();
        chk("fair_first", 32'(bus.grant), 32'b0001);
        steps(5);
        bus.req = 4'b0101;
        steps(11);
        chk("fair_done0", 32'(bus.done), 32'b0001);
        steps(2);
        chk("fair_second", 32'(bus.grant), 32'b0100);
        steps(16);
        chk("fair_done2", 32'(bus.done), 32'b0100);
        bus.req = 4'b0001;
        steps(2);
        chk("fair_third", 32'(bus.grant), 32'b0001);
        bus.req = 4'b0000;
        steps(17);
        chk("fair_idle", 32'(bus.busy), 32'd0);

        // Wrap-around at the right and bottom edges
        set_slot(3, 8'd254, 7'd126, 3'b011);
        bus.req = 4'b1000;
        step();
        chk("wrap_grant", 32'(bus.grant), 32'b1000);
        bus.req = 4'b0000;
        chk_square("wrap", 8'd254, 7'd126, 3'b011);
        chk("wrap_done", 32'(bus.done), 32'b1000);
        step();

        // Input freeze: coordinates change and req drops five cycles into the draw
        set_slot(0, 8'd40, 7'd50, 3'b010);
        bus.req = 4'b0001;
        step();
        chk("frz_grant", 32'(bus.grant), 32'b0001);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) begin
                bus.req_x[7:0] = 8'd99;
                bus.req_y[6:0] = 7'd1;
                bus.req        = 4'b0000;
            end
            chk("frz_x", 32'(bus.vga_x), 32'(8'd40 + 8'(k % 4)));
            chk("frz_y", 32'(bus.vga_y), 32'(7'd50 + 7'(k / 4)));
            chk("frz_plot", 32'(bus.plot), 32'd1);
            step();
        end
        chk("frz_done", 32'(bus.done), 32'b0001);
        steps(2);
        chk("frz_no_regrant", 32'(bus.busy), 32'd0);

        // Reset at pixel 7 of requester 1, then requester 0 wins after release
        set_slot(0, 8'd70, 7'd30, 3'b111);
        set_slot(1, 8'd5, 7'd6, 3'b001);
        bus.req = 4'b0011;
        step();
        chk("mid_grant", 32'(bus.grant), 32'b0010);
        steps(7);
        chk("mid_pix7_x", 32'(bus.vga_x), 32'd8);
        chk("mid_pix7_y", 32'(bus.vga_y), 32'd7);
        resetn = 1'b0;
        #1;
        chk("mid_rst_plot", 32'(bus.plot), 32'd0);
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        step();
        resetn = 1'b1;
        step();
        chk("mid_regrant", 32'(bus.grant), 32'b0001);
        bus.req = 4'b0000;
        chk_square("mid_restart", 8'd70, 7'd30, 3'b111);
        chk("mid_done", 32'(bus.done), 32'b0001);
        step();
        chk("mid_end_idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/square_draw_scheduler.md
# square_draw_scheduler

Round-robin scheduler sharing one 4x4-square pixel stream to the VGA adapter among NREQ independent sprite requesters, such as note lanes, score markers and erase jobs. Each requester presents a top-left coordinate and colour. The block grants one request at a time and emits the 16 pixels of that square, one per clock, on the VGA x/y/colour/plot bus. It then pulses a per-requester done. It sits between the game-logic sprite engines and the VGA adapter, and replaces direct per-sprite drivers of the plot bus.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).

Ports:
- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester draw request, level, held until done.
- req_x  in  8*NREQ  packed top-left X; requester i uses bits [8i+7:8i].
- req_y  in  7*NREQ  packed top-left Y; requester i uses bits [7i+6:7i].
- req_colour  in  3*NREQ  packed colour; requester i uses bits [3i+2:3i].
- grant  out  NREQ  one-hot; identifies the requester currently being served.
- done  out  NREQ  one-hot, 1-cycle pulse when the granted square is complete.
- busy  out  1  high whenever state != IDLE.
- vga_x  out  8  pixel X to the VGA adapter.
- vga_y  out  7  pixel Y to the VGA adapter.
- vga_colour  out  3  pixel colour to the VGA adapter.
- plot  out  1  pixel write enable to the VGA adapter.

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: at a rising edge with req != 0, the arbiter selects a winner.
  - Search order is round-robin, starting at (last+1) mod NREQ.
  - Registered on that edge: grant, the winner's x/y/colour (base_x, base_y, col), last <= winner, pix <= 0, state <= DRAW.
- DRAW: pix is a 4-bit counter incrementing every cycle.
  - vga_x = base_x + pix[1:0], truncated to 8 bits; vga_y = base_y + pix[3:2], truncated to 7 bits.
  - Row-major order: pix 0..3 is row 0 with x offsets 0..3, and so on.
  - vga_colour = col. plot = 1.
  - The edge with pix == 15 moves the state to DONE.
- DONE: done = grant for this single cycle; plot = 0. The next edge clears grant and returns to IDLE.
- Latched coordinates and colour are frozen for the whole draw. Input changes after the grant edge have no effect.
- Dropping req during DRAW does not abort; the square completes and done still pulses.
- A req still high in IDLE after done is treated as a new request and is arbitrated normally.
- Coordinate wrap-around is not clipped: base_x = 254 yields x = 254, 255, 0, 1. The VGA adapter discards off-screen pixels.
- Outside DRAW: plot = 0, and vga_x/vga_y/vga_colour hold their last values.

## Timing
- Reset (async, resetn = 0) forces immediately:
  - state = IDLE, grant = 0, done = 0, busy = 0, plot = 0.
  - vga_x = 0, vga_y = 0, vga_colour = 0, pix = 0.
  - last = NREQ-1, so requester 0 wins first.
- Reset mid-DRAW: plot drops asynchronously and no done is issued. After release the block is in IDLE, and the requester must still be holding req to be re-served.
- Grant latency: req sampled at edge E sets grant and plot high in the cycle following E.
- Pixel k (k = 0..15) is presented in cycle E+1+k. done is high in cycle E+17. IDLE resumes at E+18.
- Back-to-back service takes 18 cycles per square: 16 pixel cycles, 1 DONE cycle and 1 IDLE arbitration cycle.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority after the first grant.
- With all NREQ requesting continuously, each requester is served exactly once per NREQ grants.
- plot, vga_* and done are driven from registers or registered state only. No combinational path exists from req to any output.

## Test plan
- Single request: reset, then req[1] = 1 with x = 10, y = 20, colour = 3'b100.
  - plot is high for exactly 16 cycles.
  - Pixel sequence is (10,20), (11,20), (12,20), (13,20), (10,21) … (13,23), all with colour 100.
  - done = 4'b0010 for 1 cycle at grant + 17. busy is low 18 cycles after the grant edge.
- Simultaneous: req = 4'b1111 held after reset.
  - Grant order is 0, 1, 2, 3, 0, … with grants 18 cycles apart.
  - Each done is one-hot and matches the grant.
- Fairness: req[0] held permanently, req[2] asserted mid-draw of 0.
  - The next grant is 2, then 0. Requester 0 is never served twice in a row while 2 is waiting.
- Wrap-around: x = 254, y = 126.
  - X sequence per row is 254, 255, 0, 1; Y rows are 126, 127, 0, 1.
  - There is no stall and no clipping.
- Input freeze: change req_x, and drop req, 5 cycles into DRAW.
  - The pixels still use the latched base, all 16 are drawn, and done pulses.
- Reset mid-draw: resetn = 0 at pixel 7.
  - plot = 0 and grant = 0 in the same cycle; there is no done.
  - After release with req held, the draw restarts from pixel 0 and requester 0 has priority.
